// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multicycle CPU control path:
// opcodes, ALU codes, mux selects, FSM states and the control bundle.
package cpu_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_ANDI  = 6'h02;
    localparam logic [5:0] OP_ORI   = 6'h03;
    localparam logic [5:0] OP_LW    = 6'h04;
    localparam logic [5:0] OP_SW    = 6'h05;
    localparam logic [5:0] OP_BEQZ  = 6'h06;
    localparam logic [5:0] OP_J     = 6'h07;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_PASSA = 4'd7;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC    = 4'd2;
    localparam logic [3:0] S_ALU_WB  = 4'd3;
    localparam logic [3:0] S_MEM_RD  = 4'd4;
    localparam logic [3:0] S_LD_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR  = 4'd6;
    localparam logic [3:0] S_BR_TGT  = 4'd7;
    localparam logic [3:0] S_BR_EVAL = 4'd8;
    localparam logic [3:0] S_BR_NT   = 4'd9;
    localparam logic [3:0] S_JMP     = 4'd10;
    localparam logic [3:0] S_HALTED  = 4'd11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t pc_inc(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.alu_src_a = 1'b0;
        r.alu_src_b = SRCB_ONE;
        r.alu_op    = ALU_ADD;
        r.pc_source = PCS_ALU;
        r.pc_write  = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational state+opcode decode: control vector, next state,
// retire strobe and halt/illegal set requests.
module control_decode
    import cpu_defs_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic [3:0] funct,
    input  logic       alu_zero,
    output ctrl_t      ctrl,
    output logic [3:0] next_state,
    output logic       retire,
    output logic       halt_set,
    output logic       illegal_set
);

    always_comb begin
        ctrl        = '0;
        next_state  = state;
        retire      = 1'b0;
        halt_set    = 1'b0;
        illegal_set = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write = 1'b1;
                next_state    = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE, OP_ADDI,
                    OP_ANDI, OP_ORI: next_state = S_EXEC;
                    OP_LW:           next_state = S_MEM_RD;
                    OP_SW:           next_state = S_MEM_WR;
                    OP_BEQZ:         next_state = S_BR_TGT;
                    OP_J:            next_state = S_JMP;
                    OP_HALT: begin
                        next_state = S_HALTED;
                        halt_set   = 1'b1;
                    end
                    default: begin
                        next_state  = S_HALTED;
                        halt_set    = 1'b1;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                case (op)
                    OP_RTYPE: begin
                        ctrl.alu_src_b = SRCB_B;
                        ctrl.alu_op    = funct;
                    end
                    OP_ADDI: begin
                        ctrl.alu_src_b = SRCB_SEXT;
                        ctrl.alu_op    = ALU_ADD;
                    end
                    OP_ANDI: begin
                        ctrl.alu_src_b = SRCB_ZEXT;
                        ctrl.alu_op    = ALU_AND;
                    end
                    OP_ORI: begin
                        ctrl.alu_src_b = SRCB_ZEXT;
                        ctrl.alu_op    = ALU_OR;
                    end
                    default: ;
                endcase
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl           = pc_inc(ctrl);
                ctrl.reg_write = 1'b1;
                retire         = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                next_state    = S_LD_WB;
            end
            S_LD_WB: begin
                ctrl            = pc_inc(ctrl);
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire          = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl           = pc_inc(ctrl);
                ctrl.mem_write = 1'b1;
                retire         = 1'b1;
                next_state     = S_FETCH;
            end
            S_BR_TGT: begin
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALU_ADD;
                next_state     = S_BR_EVAL;
            end
            S_BR_EVAL: begin
                // A passes through the ALU; zero flag decides the PC write
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_PASSA;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.pc_write      = alu_zero;
                retire             = alu_zero;
                next_state         = alu_zero ? S_FETCH : S_BR_NT;
            end
            S_BR_NT: begin
                ctrl       = pc_inc(ctrl);
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                retire         = 1'b1;
                next_state     = S_FETCH;
            end
            S_HALTED: next_state = S_HALTED;
            default:  next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register, sticky halt/illegal
// flags and retired-instruction counter around control_decode.
module multicycle_control
    import cpu_defs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IReg_out,
    input  logic             alu_zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] state;
    logic [3:0] next_state;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;
    logic       retire;
    logic       halt_set;
    logic       illegal_set;
    logic       unused_ir;

    assign unused_ir = ^IReg_out[25:4];

    control_decode u_decode (
        .state       (state),
        .op          (IReg_out[31:26]),
        .funct       (IReg_out[3:0]),
        .alu_zero    (alu_zero),
        .ctrl        (dec_ctrl),
        .next_state  (next_state),
        .retire      (retire),
        .halt_set    (halt_set),
        .illegal_set (illegal_set)
    );

    // Reset is applied combinationally so an aborted instruction
    // cannot leak a write while reset is held.
    assign ctrl = reset ? '0 : dec_ctrl;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = 1'b0;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = 1'b0;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (halt_set)
                halted <= 1'b1;
            if (illegal_set)
                illegal_op <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors,
// retire counting, halt/illegal flags and asynchronous reset abort.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IReg_out = '0;
    logic        alu_zero = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic        IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp;
    logic        halted, illegal_op;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .IReg_out    (IReg_out),
        .alu_zero    (alu_zero),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    logic [17:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                  IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst,
                  PCSource, ALUSrcB, ALUOp};

    function automatic logic [17:0] cv(
        input logic pcw, pcwc, mr, mw, irw, m2r, asa, rw,
        input logic [1:0] pcs, asb, input logic [3:0] aop);
        return {pcw, pcwc, 1'b0, mr, mw, irw, m2r, asa, rw, 1'b0,
                pcs, asb, aop};
    endfunction

    localparam logic [17:0] E_FETCH = cv(0,0,0,0,1,0,0,0,2'b00,2'b00,4'd0);
    localparam logic [17:0] E_NONE  = 18'd0;
    localparam logic [17:0] E_ADDI  = cv(0,0,0,0,0,0,1,0,2'b00,2'b10,4'd0);
    localparam logic [17:0] E_RSLL  = cv(0,0,0,0,0,0,1,0,2'b00,2'b00,4'd5);
    localparam logic [17:0] E_ORI   = cv(0,0,0,0,0,0,1,0,2'b00,2'b11,4'd3);
    localparam logic [17:0] E_ALUWB = cv(1,0,0,0,0,0,0,1,2'b00,2'b01,4'd0);
    localparam logic [17:0] E_MEMRD = cv(0,0,1,0,0,0,0,0,2'b00,2'b00,4'd0);
    localparam logic [17:0] E_LDWB  = cv(1,0,0,0,0,1,0,1,2'b00,2'b01,4'd0);
    localparam logic [17:0] E_MEMWR = cv(1,0,0,1,0,0,0,0,2'b00,2'b01,4'd0);
    localparam logic [17:0] E_BRTGT = cv(0,0,0,0,0,0,0,0,2'b00,2'b10,4'd0);
    localparam logic [17:0] E_BRT   = cv(1,1,0,0,0,0,1,0,2'b01,2'b00,4'd7);
    localparam logic [17:0] E_BRN   = cv(0,1,0,0,0,0,1,0,2'b01,2'b00,4'd7);
    localparam logic [17:0] E_BRNT  = cv(1,0,0,0,0,0,0,0,2'b00,2'b01,4'd0);
    localparam logic [17:0] E_JMP   = cv(1,0,0,0,0,0,0,0,2'b10,2'b00,4'd0);

    localparam logic [31:0] I_ADDI = {6'h01, 5'd1, 5'd2, 16'hFFFF};
    localparam logic [31:0] I_RSLL = {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h05};
    localparam logic [31:0] I_ORI  = {6'h03, 5'd6, 5'd7, 16'h00F0};
    localparam logic [31:0] I_LW   = {6'h04, 5'd1, 5'd0, 16'h0010};
    localparam logic [31:0] I_SW   = {6'h05, 5'd0, 5'd1, 16'h0011};
    localparam logic [31:0] I_BEQZ = {6'h06, 5'd0, 5'd1, 16'hFFFE};
    localparam logic [31:0] I_J    = {6'h07, 26'h0000123};
    localparam logic [31:0] I_ILL  = {6'h2A, 26'h0};
    localparam logic [31:0] I_HALT = {6'h3F, 26'h0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [31:0] ir);
        IReg_out = ir;
        alu_zero = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctl !== E_NONE) begin
            errors++;
            $display("FAIL reset_ctl got=%h exp=%h", ctl, E_NONE);
        end
        checks++;
        if ({halted, illegal_op, instr_count} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state got h=%b i=%b cnt=%0d exp 0",
                     halted, illegal_op, instr_count);
        end
    endtask

    task automatic test_alu_ops();
        logic [17:0] exp_a [4] = '{E_FETCH, E_NONE, E_ADDI, E_ALUWB};
        logic [17:0] exp_r [4] = '{E_FETCH, E_NONE, E_RSLL, E_ALUWB};
        logic [17:0] exp_o [4] = '{E_FETCH, E_NONE, E_ORI, E_ALUWB};
        apply_reset(I_ADDI);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== exp_a[i]) begin
                errors++;
                $display("FAIL addi c%0d got=%h exp=%h", i, ctl, exp_a[i]);
            end
            step();
        end
        checks++;
        if (ctl !== E_FETCH || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL addi_end got ctl=%h cnt=%0d exp ctl=%h cnt=1",
                     ctl, instr_count, E_FETCH);
        end
        IReg_out = I_RSLL;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== exp_r[i]) begin
                errors++;
                $display("FAIL rtype c%0d got=%h exp=%h", i, ctl, exp_r[i]);
            end
            step();
        end
        IReg_out = I_ORI;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== exp_o[i]) begin
                errors++;
                $display("FAIL ori c%0d got=%h exp=%h", i, ctl, exp_o[i]);
            end
            step();
        end
        checks++;
        if (instr_count !== 32'd3) begin
            errors++;
            $display("FAIL alu_count got=%0d exp=3", instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_l [4] = '{E_FETCH, E_NONE, E_MEMRD, E_LDWB};
        logic [17:0] exp_s [3] = '{E_FETCH, E_NONE, E_MEMWR};
        apply_reset(I_LW);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== exp_l[i]) begin
                errors++;
                $display("FAIL lw c%0d got=%h exp=%h", i, ctl, exp_l[i]);
            end
            step();
        end
        IReg_out = I_SW;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== exp_s[i]) begin
                errors++;
                $display("FAIL sw c%0d got=%h exp=%h", i, ctl, exp_s[i]);
            end
            step();
        end
        checks++;
        if (ctl !== E_FETCH || instr_count !== 32'd2) begin
            errors++;
            $display("FAIL lwsw_end got ctl=%h cnt=%0d exp ctl=%h cnt=2",
                     ctl, instr_count, E_FETCH);
        end
    endtask

    task automatic test_branch();
        logic [17:0] exp_t [4] = '{E_FETCH, E_NONE, E_BRTGT, E_BRT};
        logic [17:0] exp_n [5] = '{E_FETCH, E_NONE, E_BRTGT, E_BRN, E_BRNT};
        apply_reset(I_BEQZ);
        alu_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== exp_t[i]) begin
                errors++;
                $display("FAIL beqz_t c%0d got=%h exp=%h", i, ctl, exp_t[i]);
            end
            step();
        end
        checks++;
        if (ctl !== E_FETCH || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL beqz_t_end got ctl=%h cnt=%0d exp ctl=%h cnt=1",
                     ctl, instr_count, E_FETCH);
        end
        alu_zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== exp_n[i]) begin
                errors++;
                $display("FAIL beqz_n c%0d got=%h exp=%h", i, ctl, exp_n[i]);
            end
            if (i == 3) begin
                checks++;
                if (instr_count !== 32'd1) begin
                    errors++;
                    $display("FAIL beqz_n_early got=%0d exp=1", instr_count);
                end
            end
            step();
        end
        checks++;
        if (ctl !== E_FETCH || instr_count !== 32'd2) begin
            errors++;
            $display("FAIL beqz_n_end got ctl=%h cnt=%0d exp ctl=%h cnt=2",
                     ctl, instr_count, E_FETCH);
        end
    endtask

    task automatic test_jump();
        logic [17:0] exp_j [3] = '{E_FETCH, E_NONE, E_JMP};
        apply_reset(I_J);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl !== exp_j[i]) begin
                errors++;
                $display("FAIL jmp c%0d got=%h exp=%h", i, ctl, exp_j[i]);
            end
            step();
        end
        checks++;
        if (ctl !== E_FETCH || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL jmp_end got ctl=%h cnt=%0d exp ctl=%h cnt=1",
                     ctl, instr_count, E_FETCH);
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        apply_reset(I_ILL);
        step();
        checks++;
        if (ctl !== E_NONE || halted !== 1'b0) begin
            errors++;
            $display("FAIL ill_decode got ctl=%h h=%b exp ctl=0 h=0",
                     ctl, halted);
        end
        step();
        checks++;
        if ({halted, illegal_op} !== 2'b11 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL ill_flags got h=%b i=%b cnt=%0d exp h=1 i=1 cnt=0",
                     halted, illegal_op, instr_count);
        end
        for (int i = 0; i < 50; i++) begin
            if (ctl !== E_NONE) bad++;
            step();
        end
        checks++;
        if (bad !== 0 || halted !== 1'b1 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL ill_absorb got bad=%0d h=%b cnt=%0d exp 0,1,0",
                     bad, halted, instr_count);
        end
        apply_reset(I_HALT);
        checks++;
        if ({halted, illegal_op} !== 2'b00) begin
            errors++;
            $display("FAIL halt_clear got h=%b i=%b exp 0 0",
                     halted, illegal_op);
        end
        repeat (2) step();
        checks++;
        if ({halted, illegal_op} !== 2'b10 || ctl !== E_NONE) begin
            errors++;
            $display("FAIL halt_flags got h=%b i=%b ctl=%h exp h=1 i=0 ctl=0",
                     halted, illegal_op, ctl);
        end
    endtask

    task automatic test_reset_abort();
        apply_reset(I_ADDI);
        repeat (4) step();
        repeat (2) step();
        checks++;
        if (ctl !== E_ADDI || instr_count !== 32'd1) begin
            errors++;
            $display("FAIL abort_pre got ctl=%h cnt=%0d exp ctl=%h cnt=1",
                     ctl, instr_count, E_ADDI);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ctl !== E_NONE || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_drop got ctl=%h cnt=%0d exp ctl=0 cnt=0",
                     ctl, instr_count);
        end
        step();
        checks++;
        if (RegWrite !== 1'b0 || PCWrite !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold got rw=%b pcw=%b mw=%b exp 0 0 0",
                     RegWrite, PCWrite, MemWrite);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (ctl !== E_FETCH || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_release got ctl=%h cnt=%0d exp ctl=%h cnt=0",
                     ctl, instr_count, E_FETCH);
        end
        step();
        checks++;
        if (ctl !== E_NONE) begin
            errors++;
            $display("FAIL abort_decode got ctl=%h exp=0", ctl);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_branch();
        test_jump();
        test_halt();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multicycle datapath. It decodes the registered instruction `IReg_out` and drives every datapath control line, state by state.
- Sits beside the datapath at the CPU top level. Adds halt/illegal reporting and a retired-instruction counter for the bench.
- Requires one datapath hookup: `alu_zero = (ALU_out == 0)`, taken combinationally from the unregistered ALU result.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IReg_out  in  32  instruction register contents: op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11], imm=[15:0], funct=[5:0].
- alu_zero  in  1  combinational zero flag of the current-cycle ALU result.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- PCSource  out  2  00=ALU result, 01=ALUOut reg, 10={6'b0,imm26}, 11=0.
- ALUSrcB  out  2  00=B, 01=const 1, 10=sign-ext imm, 11=zero-ext imm.
- ALUOp  out  4  ALU function.
- halted  out  1  sticky, set on HALT or illegal opcode.
- illegal_op  out  1  sticky, set only on illegal opcode.
- instr_count  out  CNT_W  number of instructions retired.

Behaviour:
- Reset (async): state<=FETCH, halted=0, illegal_op=0, instr_count=0. While reset is high, all write enables (PCWrite, RegWrite, MemWrite) are 0. Reset asserted mid-instruction aborts the instruction with no partial write after assertion.
- Default outputs are 0 in every state. IorD=0 and RegDst=0 always (destination is always rd).
- Shared "PC+1" bundle: ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1.
- Opcodes:
  - RTYPE=00: ALUOp=funct[3:0].
  - ADDI=01: ALUOp=ADD, operand is sign-extended imm.
  - ANDI=02: ALUOp=AND, operand is zero-extended imm.
  - ORI=03: ALUOp=OR, operand is zero-extended imm.
  - LW=04, SW=05, BEQZ=06, J=07, HALT=3F.
  - Any other opcode is illegal.
- States:
  - FETCH: IRWrite=1. IR captures IMem(PC) at the edge. Next: DECODE.
  - DECODE: register file read. A and B latch at the edge. Next state by opcode:
    - RTYPE/ADDI/ANDI/ORI -> EXEC
    - LW -> MEM_RD
    - SW -> MEM_WR
    - BEQZ -> BR_TGT
    - J -> JMP
    - HALT -> HALTED
    - illegal -> HALTED, and sets illegal_op.
  - EXEC: ALUSrcA=1. ALUSrcB=00 (RTYPE), 10 (ADDI) or 11 (ANDI/ORI). ALUOp per opcode. Next: ALU_WB.
  - ALU_WB: RegWrite=1, MemtoReg=0, plus the PC+1 bundle. Retire. Next: FETCH.
  - MEM_RD: MemRead=1. MDR captures DMem[imm]. Next: LD_WB.
  - LD_WB: RegWrite=1, MemtoReg=1, plus PC+1. Retire. Next: FETCH.
  - MEM_WR: MemWrite=1 (DMem[imm]<=A), plus PC+1. Retire. Next: FETCH.
  - BR_TGT: ALUSrcA=0, ALUSrcB=10, ALUOp=ADD, so ALUOut<=PC+sext(imm). Next: BR_EVAL.
  - BR_EVAL: ALUSrcA=1, ALUOp=PASSA, PCWriteCond=1, PCSource=01, PCWrite=alu_zero (Mealy).
    - alu_zero=1: retire, next FETCH.
    - alu_zero=0: next BR_NT.
  - BR_NT: PC+1 bundle. Retire. Next: FETCH.
  - JMP: PCWrite=1, PCSource=10. Retire. Next: FETCH.
  - HALTED: all enables 0, halted=1. Absorbing until reset.
- Latency in cycles: ALU ops 4, LW 4, SW 3, J 3, BEQZ taken 4, BEQZ not taken 5.
- instr_count increments by 1 on each retire edge and wraps modulo 2^CNT_W. HALT and illegal opcodes do not count.
- ALU codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, PASSA=7.
  - RTYPE funct[3:0] passes through unchecked.

Decomposition:
- Shared package `cpu_defs_pkg` holds:
  - opcode constants
  - ALU op codes
  - PCSource and ALUSrcB encodings
  - the state enum (4-bit encoding)
- One sub-module is natural: `control_decode`, the combinational state+opcode -> control-vector decode. The state register, counter and sticky flags stay in `multicycle_control`.

Test Plan:
- Reset, release, IReg_out=ADDI rd=1 rs=2 imm=16'hFFFF -> state sequence FETCH, DECODE, EXEC, ALU_WB. In EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=0. In ALU_WB: RegWrite=1, PCWrite=1, PCSource=00. instr_count=1.
- LW then SW back-to-back -> LW: MemRead=1 in cycle 3, RegWrite=1 and MemtoReg=1 in cycle 4. SW: MemWrite=1 only in cycle 3. instr_count=2 after 7 cycles.
- BEQZ with alu_zero=1 in BR_EVAL -> PCWrite=1 with PCSource=01, back to FETCH after 4 cycles. With alu_zero=0 -> PCWrite=0 in BR_EVAL, then BR_NT asserts PCWrite with PCSource=00, 5 cycles total.
- J -> JMP asserts PCWrite=1, PCSource=10 in cycle 3. RegWrite and MemWrite stay 0 throughout.
- Opcode 6'h2A -> HALTED after DECODE, halted=1, illegal_op=1, instr_count unchanged. 50 further cycles produce no enables. Opcode HALT -> halted=1, illegal_op=0.
- Assert reset asynchronously mid-EXEC (between clock edges) -> outputs drop immediately, RegWrite never fires. After release: FETCH with instr_count=0.
